// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer slice.
package cpu_sequencer_pkg;

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2
    } seqState_t;

    localparam int PC_WIDTH    = 8;
    localparam int COUNT_WIDTH = 16;

    // Operand-source field value meaning "immediate byte follows in ROM".
    localparam logic [2:0] SRC_ROM = 3'd0;

    localparam logic [PC_WIDTH-1:0]    PC_ONE    = 8'd1;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = 16'd1;

    // A taken jump whose target is the first byte of the current instruction
    // would spin forever; pc has already advanced past that byte in FETCH.
    function automatic logic isSelfLoop(
        input logic                doJumpBar,
        input logic [PC_WIDTH-1:0] target,
        input logic [PC_WIDTH-1:0] pcAfterFetch
    );
        return (!doJumpBar) && (target == (pcAfterFetch - PC_ONE));
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Control/ROM/decoder signal bundle between the sequencer and its surroundings.
interface cpu_sequencer_if;
    import cpu_sequencer_pkg::*;

    logic                   run;
    logic                   step;
    logic [7:0]             romData;
    logic [7:0]             bus;
    logic                   doJumpBar;
    logic [PC_WIDTH-1:0]    pc;
    logic [7:0]             ir;
    logic                   execEn;
    logic                   halted;
    logic                   stuck;
    logic [COUNT_WIDTH-1:0] instrCount;

    // Environment side: supplies requests, ROM byte, bus and decoder result.
    modport master (
        output run, step, romData, bus, doJumpBar,
        input  pc, ir, execEn, halted, stuck, instrCount
    );

    // Sequencer side.
    modport slave (
        input  run, step, romData, bus, doJumpBar,
        output pc, ir, execEn, halted, stuck, instrCount
    );
endinterface

// File: rtl/cpu_sequencer_edge_detect.sv
// Rising-edge detector for the single-step request.
module edge_detect (
    input  logic clk,
    input  logic resetBar,
    input  logic sigIn,
    output logic rise
);

    logic prevR;

    // Remember last cycle's level so a held input produces only one pulse.
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            prevR <= 1'b0;
        end else begin
            prevR <= sigIn;
        end
    end

    assign rise = sigIn & ~prevR;

endmodule

// File: rtl/cpu_sequencer.sv
// Two-cycle fetch/execute sequencer: owns pc, ir, retire counter and halt logic.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
(
    input logic            clk,
    input logic            resetBar,
    cpu_sequencer_if.slave sif
);

    seqState_t              stateR,      stateNextS;
    logic [PC_WIDTH-1:0]    pcR,         pcNextS;
    logic [7:0]             irR,         irNextS;
    logic [COUNT_WIDTH-1:0] instrCountR, instrCountNextS;
    logic                   stuckR,      stuckNextS;
    logic                   stepOnceR,   stepOnceNextS;
    logic                   stepRiseS;
    logic                   selfLoopS;

    edge_detect u_stepEdge (
        .clk      (clk),
        .resetBar (resetBar),
        .sigIn    (sif.step),
        .rise     (stepRiseS)
    );

    // State and datapath registers; reset aborts any in-flight instruction.
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            stateR      <= HALTED;
            pcR         <= 8'h00;
            irR         <= 8'h00;
            instrCountR <= 16'h0000;
            stuckR      <= 1'b0;
            stepOnceR   <= 1'b0;
        end else begin
            stateR      <= stateNextS;
            pcR         <= pcNextS;
            irR         <= irNextS;
            instrCountR <= instrCountNextS;
            stuckR      <= stuckNextS;
            stepOnceR   <= stepOnceNextS;
        end
    end

    // Next-state and datapath update rules for each sequencer state.
    always_comb begin
        stateNextS      = stateR;
        pcNextS         = pcR;
        irNextS         = irR;
        instrCountNextS = instrCountR;
        stuckNextS      = stuckR;
        stepOnceNextS   = stepOnceR;
        selfLoopS       = 1'b0;

        case (stateR)
            HALTED: begin
                if (sif.run && !stuckR) begin
                    // Continuous run wins over a coincident step edge.
                    stateNextS = FETCH;
                end else if (stepRiseS) begin
                    // A step also clears a self-loop halt and runs one instruction.
                    stateNextS    = FETCH;
                    stepOnceNextS = 1'b1;
                    stuckNextS    = 1'b0;
                end else if (!sif.run) begin
                    stuckNextS = 1'b0;
                end else begin
                    stateNextS = HALTED;
                end
            end

            FETCH: begin
                irNextS    = sif.romData;
                pcNextS    = pcR + PC_ONE;
                stateNextS = EXEC;
            end

            EXEC: begin
                selfLoopS       = isSelfLoop(sif.doJumpBar, sif.bus, pcR);
                instrCountNextS = instrCountR + COUNT_ONE;
                stepOnceNextS   = 1'b0;

                if (!sif.doJumpBar) begin
                    pcNextS = sif.bus;
                end else if (irR[2:0] == SRC_ROM) begin
                    // Skip over the immediate operand byte.
                    pcNextS = pcR + PC_ONE;
                end else begin
                    pcNextS = pcR;
                end

                if (selfLoopS) begin
                    stuckNextS = 1'b1;
                end else begin
                    stuckNextS = stuckR;
                end

                if (sif.run && !stepOnceR && !selfLoopS) begin
                    stateNextS = FETCH;
                end else begin
                    stateNextS = HALTED;
                end
            end

            default: begin
                stateNextS = HALTED;
            end
        endcase
    end

    assign sif.pc         = pcR;
    assign sif.ir         = irR;
    assign sif.instrCount = instrCountR;
    assign sif.stuck      = stuckR;
    assign sif.execEn     = (stateR == EXEC);
    assign sif.halted     = (stateR == HALTED);

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have port clk  input  1  single CPU clock; all state updates on rising edge.
REQ-002 SHALL have port resetBar  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port run  input  1  level request for continuous execution.
REQ-004 SHALL have port step  input  1  single-instruction request; acts on its rising edge only.
REQ-005 SHALL have port romData  input  8  ROM byte at address pc.
REQ-006 SHALL have port bus  input  8  current data-bus value; supplies the jump target.
REQ-007 SHALL have port doJumpBar  input  1  active-low "jump taken" from the instruction decoder.
REQ-008 SHALL have port pc  output  8  program counter; drives the ROM address.
REQ-009 SHALL have port ir  output  8  instruction register, fed to the decoder.
REQ-010 SHALL have port execEn  output  1  high for exactly the EXEC cycle; gates all datapath load triggers.
REQ-011 SHALL have port halted  output  1  high while in HALTED.
REQ-012 SHALL have port stuck  output  1  self-loop halt flag.
REQ-013 SHALL have port instrCount  output  16  count of retired instructions.

Function
REQ-014 SHALL implement 3 states: HALTED, FETCH, EXEC.
REQ-015 HALTED -> FETCH when run=1 and stuck=0; also HALTED -> FETCH on a step rising edge (stepOnce:=1). Otherwise stays in HALTED.
REQ-016 FETCH SHALL load ir:=romData and set pc:=pc+1 (8-bit wrap, 0xFF->0x00), then go to EXEC.
REQ-017 EXEC SHALL assert execEn for exactly 1 cycle.
REQ-018 EXEC next pc: if doJumpBar=0, pc:=bus; else if ir[2:0]==0 (ROM-immediate source), pc:=pc+1; else pc unchanged.
REQ-019 EXEC SHALL increment instrCount by 1 (16-bit wrap, 0xFFFF->0x0000).
REQ-020 Self-loop: in EXEC, if doJumpBar=0 and bus equals the address of the instruction's first byte (pc-1 mod 256), the block SHALL set stuck:=1 and go to HALTED.
REQ-021 EXEC next state: FETCH if run=1, stepOnce=0 and no self-loop; otherwise HALTED. stepOnce clears on leaving EXEC.
REQ-022 run deasserted mid-instruction SHALL let the current instruction complete through EXEC before entering HALTED.
REQ-023 step edges SHALL be ignored outside HALTED; if run and a step edge occur together in HALTED, run takes priority and stepOnce stays 0.
REQ-024 stuck SHALL clear when run=0 or on a step edge in HALTED. A step edge while stuck=1 clears stuck and executes one instruction.
REQ-025 ir, pc and instrCount SHALL hold their values in HALTED; pc is visible to the ROM in every state.
REQ-026 Minimum instruction latency SHALL be 2 cycles (FETCH+EXEC); throughput while running SHALL be 1 instruction per 2 cycles.

Reset
REQ-027 resetBar=0 SHALL asynchronously force: state=HALTED, pc=0x00, ir=0x00, instrCount=0x0000, stuck=0, stepOnce=0, step-edge history=0, execEn=0, halted=1.
REQ-028 Reset asserted mid-EXEC SHALL abort the instruction; instrCount is not incremented.
REQ-029 After resetBar is released, the first transition SHALL occur on the next clk rising edge, subject to REQ-015.

Structure
REQ-030 A shared package SHALL hold the state enum, PC_WIDTH=8, COUNT_WIDTH=16 and SRC_ROM=3'd0.
REQ-031 Step rising-edge detection SHALL be one sub-module, edge_detect, with clk and resetBar ports.
REQ-032 All outputs SHALL be registered or decoded from state only; there is no combinational path from any input to execEn or halted.

Verification
REQ-033 Reset, then run=1 with ROM holding a non-ROM-source instruction at 0x00 -> FETCH at cycle 1, EXEC at cycle 2 with execEn=1, then pc=0x01 and instrCount=1.
REQ-034 ROM-source instruction (ir[2:0]=0) at pc=0x10, doJumpBar=1 -> pc=0x12 after EXEC.
REQ-035 Jump with bus=0x40 from an instruction at 0x20 -> pc=0x40; jump with bus=0x20 from 0x20 -> stuck=1, halted=1; run low then high -> execution resumes.
REQ-036 Halted, step pulsed 3 cycles high -> exactly one instruction retires (instrCount +1) and the block returns to HALTED; step held high does not retrigger.
REQ-037 pc=0xFF, non-jump ROM-source instruction -> pc wraps to 0x01; instrCount at 0xFFFF wraps to 0x0000.
REQ-038 resetBar pulsed low mid-EXEC -> immediate HALTED, pc=0x00, instrCount unchanged from 0.
